// File: rtl/multicycle_alu_pkg.sv
// Shared opcode map, FSM encoding and default sizes for the multicycle ALU.
// Opcodes 13..31 are illegal and produce a zero result.
package multicycle_alu_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_CTRL_W = 5;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_MUL  = 2;
  localparam int OP_DIV  = 3;
  localparam int OP_SHR  = 4;
  localparam int OP_SHL  = 5;
  localparam int OP_ROR  = 6;
  localparam int OP_ROL  = 7;
  localparam int OP_AND  = 8;
  localparam int OP_OR   = 9;
  localparam int OP_NEG  = 10;
  localparam int OP_NOT  = 11;
  localparam int OP_SHRA = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/multicycle_alu_iter_muldiv.sv
// Iterative unsigned core: shift-add multiplier and restoring divider,
// one result bit per step, both paths sharing a single WIDTH+1-bit adder.
module multicycle_alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_load,
  input  logic             i_mode,  // 0: multiply, 1: divide
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic             r_mode;
  logic [WIDTH:0]   w_x;
  logic [WIDTH:0]   w_y;
  logic [WIDTH+1:0] w_sum;

  // Divide computes {hi,lo_msb} - b; bit WIDTH+1 of the sum is the no-borrow flag.
  always_comb begin
    w_x   = r_mode ? {r_hi, r_lo[WIDTH-1]} : {1'b0, r_hi};
    w_y   = r_mode ? ~{1'b0, r_b} : {1'b0, r_b};
    w_sum = {1'b0, w_x} + {1'b0, w_y} + {{(WIDTH+1){1'b0}}, r_mode};
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
      r_mode <= 1'b0;
    end else if (i_load) begin
      r_hi   <= '0;
      r_lo   <= i_a;
      r_b    <= i_b;
      r_mode <= i_mode;
    end else if (i_step) begin
      if (r_mode) begin
        if (w_sum[WIDTH+1]) begin
          r_hi <= w_sum[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= w_x[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
      end else if (r_lo[0]) begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end else begin
        r_hi <= {1'b0, r_hi[WIDTH-1:1]};
        r_lo <= {r_hi[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU: single-cycle ops finish in one cycle, signed mul/div run
// WIDTH iterations on magnitudes and then get their signs fixed in FIX.
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int SH_W   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  output logic [WIDTH-1:0]  zHI,
  output logic [WIDTH-1:0]  zLOW,
  output logic              busy,
  output logic              done,
  output logic              dbz,
  output state_t            o_dbg_state
);

  // Handshake: start is taken on any rising edge where the FSM is IDLE or DONE
  // (busy=0); done pulses once when zHI/zLOW/dbz become valid; starts while busy are dropped.
  localparam logic [SH_W:0]   W_L      = (SH_W+1)'(WIDTH);
  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);

  state_t             r_state, w_next;
  logic [SH_W-1:0]    r_cnt;
  logic               r_sa, r_sb, r_div, r_bz;
  logic [WIDTH-1:0]   r_zhi, r_zlo;
  logic               r_dbz;
  logic               w_accept, w_is_md, w_is_div;
  logic [SH_W-1:0]    w_sh;
  logic [SH_W:0]      w_sh_inv;
  logic [WIDTH-1:0]   w_result, w_a_mag, w_b_mag;
  logic [WIDTH-1:0]   w_core_hi, w_core_lo, w_quo, w_rem;
  logic [2*WIDTH-1:0] w_prod;

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_is_div = (ctrl == CTRL_W'(OP_DIV));
  assign w_is_md  = (ctrl == CTRL_W'(OP_MUL)) || w_is_div;
  assign w_a_mag  = A[WIDTH-1] ? -A : A;
  assign w_b_mag  = B[WIDTH-1] ? -B : B;
  assign w_sh     = B[SH_W-1:0];
  assign w_sh_inv = W_L - {1'b0, w_sh};

  always_comb begin
    w_result = '0;
    case (ctrl)
      CTRL_W'(OP_ADD):  w_result = A + B;
      CTRL_W'(OP_SUB):  w_result = A - B;
      CTRL_W'(OP_SHR):  w_result = A >> w_sh;
      CTRL_W'(OP_SHL):  w_result = A << w_sh;
      CTRL_W'(OP_ROR):  w_result = (A >> w_sh) | (A << w_sh_inv);
      CTRL_W'(OP_ROL):  w_result = (A << w_sh) | (A >> w_sh_inv);
      CTRL_W'(OP_AND):  w_result = A & B;
      CTRL_W'(OP_OR):   w_result = A | B;
      CTRL_W'(OP_NEG):  w_result = -A;
      CTRL_W'(OP_NOT):  w_result = ~A;
      CTRL_W'(OP_SHRA): w_result = $signed(A) >>> w_sh;
      default:          w_result = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_accept ? (w_is_md ? S_RUN : S_DONE) : S_IDLE;
      S_RUN:          if (r_cnt == CNT_LAST) w_next = S_FIX;
      S_FIX:          w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  multicycle_alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter_muldiv (
    .clk    (clk),
    .clr    (clr),
    .i_load (w_accept && w_is_md),
    .i_mode (w_is_div),
    .i_step (r_state == S_RUN),
    .i_a    (w_a_mag),
    .i_b    (w_b_mag),
    .o_hi   (w_core_hi),
    .o_lo   (w_core_lo)
  );

  // With a zero divisor the remainder accumulator ends holding |A|, so the
  // dividend-sign fixup turns it back into A.
  assign w_prod = {w_core_hi, w_core_lo};
  assign w_quo  = (r_sa ^ r_sb) ? -w_core_lo : w_core_lo;
  assign w_rem  = r_sa ? -w_core_hi : w_core_hi;

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_div   <= 1'b0;
      r_bz    <= 1'b0;
      r_zhi   <= '0;
      r_zlo   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt <= '0;
        if (w_is_md) begin
          r_sa  <= A[WIDTH-1];
          r_sb  <= B[WIDTH-1];
          r_div <= w_is_div;
          r_bz  <= (B == '0);
        end else begin
          r_zlo <= w_result;
          r_zhi <= '0;
          r_dbz <= 1'b0;
        end
      end else if (r_state == S_RUN) begin
        if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_FIX) begin
        r_dbz <= r_div && r_bz;
        if (!r_div) begin
          {r_zhi, r_zlo} <= (r_sa ^ r_sb) ? -w_prod : w_prod;
        end else begin
          r_zlo <= r_bz ? '1 : w_quo;
          r_zhi <= w_rem;
        end
      end
    end
  end

  assign zHI         = r_zhi;
  assign zLOW        = r_zlo;
  assign dbz         = r_dbz;
  assign busy        = (r_state == S_RUN) || (r_state == S_FIX);
  assign done        = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at WIDTH=32 with hand-computed results.
module tb_multicycle_alu;
  import multicycle_alu_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [4:0]  ctrl;
  logic [31:0] a_in, b_in;
  logic [31:0] z_hi, z_lo;
  logic        busy, done, dbz;
  state_t      dbg_state;

  int checks   = 0;
  int failures = 0;

  multicycle_alu #(.WIDTH(32), .CTRL_W(5)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .ctrl        (ctrl),
    .A           (a_in),
    .B           (b_in),
    .zHI         (z_hi),
    .zLOW        (z_lo),
    .busy        (busy),
    .done        (done),
    .dbz         (dbz),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Drives one request, scrambles operands after acceptance, and measures
  // start-to-done latency (in cycles) plus the number of cycles busy was high.
  task automatic run_op(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int busy_cyc);
    @(negedge clk);
    start = 1'b1; ctrl = op; a_in = av; b_in = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ctrl  = 5'($urandom_range(0, 31));
    a_in  = $urandom;
    b_in  = $urandom;
    lat = 1;
    busy_cyc = 0;
    forever begin
      if (busy) busy_cyc++;
      if (done || lat >= 100) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    clr = 1'b0; start = 1'b0; ctrl = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (z_hi !== 32'h0) begin failures++; $display("FAIL reset_zhi got=%h exp=0", z_hi); end
    checks++; if (z_lo !== 32'h0) begin failures++; $display("FAIL reset_zlo got=%h exp=0", z_lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    clr = 1'b1;
  endtask

  task automatic test_add;
    int lat, bc;
    run_op(5'd0, 32'd7, 32'd5, lat, bc);
    checks++; if (lat != 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
    checks++; if (z_lo !== 32'd12) begin failures++; $display("FAIL add_zlo got=%h exp=0000000c", z_lo); end
    checks++; if (z_hi !== 32'd0) begin failures++; $display("FAIL add_zhi got=%h exp=0", z_hi); end
    checks++; if (bc != 0) begin failures++; $display("FAIL add_busy_cycles got=%0d exp=0", bc); end
  endtask

  task automatic test_single_cycle_ops;
    logic [4:0]  ops [13] = '{5'd6, 5'd7, 5'd12, 5'd4, 5'd5, 5'd5, 5'd8, 5'd9,
                              5'd10, 5'd11, 5'd1, 5'd0, 5'd20};
    logic [31:0] av  [13] = '{32'h00000001, 32'h80000001, 32'h80000000, 32'hF0000000,
                              32'h00000001, 32'h00000001, 32'hF0F0F0F0, 32'hF0F0F0F0,
                              32'h00000005, 32'h00000000, 32'h00000003, 32'hFFFFFFFF,
                              32'h12345678};
    logic [31:0] bv  [13] = '{32'd1, 32'd4, 32'd31, 32'd4, 32'd31, 32'h00000021,
                              32'hFF00FF00, 32'h0F000F00, 32'd0, 32'd0, 32'd5, 32'd1,
                              32'h9ABCDEF0};
    logic [31:0] ev  [13] = '{32'h80000000, 32'h00000018, 32'hFFFFFFFF, 32'h0F000000,
                              32'h80000000, 32'h00000002, 32'hF000F000, 32'hFFF0FFF0,
                              32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000000,
                              32'h00000000};
    int lat, bc;
    for (int i = 0; i < 13; i++) begin
      run_op(ops[i], av[i], bv[i], lat, bc);
      checks++;
      if (z_lo !== ev[i] || z_hi !== 32'h0 || lat != 1) begin
        failures++;
        $display("FAIL op%0d_vec%0d got lo=%h hi=%h lat=%0d exp lo=%h hi=0 lat=1",
                 ops[i], i, z_lo, z_hi, lat, ev[i]);
      end
    end
  endtask

  task automatic test_mul;
    int lat, bc;
    run_op(5'd2, 32'hFFFFFFFD, 32'd4, lat, bc);
    checks++; if (lat != 34) begin failures++; $display("FAIL mul_latency got=%0d exp=34", lat); end
    checks++; if (bc != 33) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=33", bc); end
    checks++; if (z_hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mul_neg_zhi got=%h exp=ffffffff", z_hi); end
    checks++; if (z_lo !== 32'hFFFFFFF4) begin failures++; $display("FAIL mul_neg_zlo got=%h exp=fffffff4", z_lo); end
    run_op(5'd2, 32'h80000000, 32'h80000000, lat, bc);
    checks++;
    if (z_hi !== 32'h40000000 || z_lo !== 32'h0) begin
      failures++; $display("FAIL mul_minmin got=%h_%h exp=40000000_00000000", z_hi, z_lo);
    end
    run_op(5'd2, 32'd7, 32'hFFFFFFFA, lat, bc);
    checks++;
    if (z_hi !== 32'hFFFFFFFF || z_lo !== 32'hFFFFFFD6) begin
      failures++; $display("FAIL mul_pos_neg got=%h_%h exp=ffffffff_ffffffd6", z_hi, z_lo);
    end
  endtask

  task automatic test_div;
    int lat, bc;
    run_op(5'd3, 32'hFFFFFFF9, 32'd2, lat, bc);
    checks++; if (lat != 34) begin failures++; $display("FAIL div_latency got=%0d exp=34", lat); end
    checks++; if (z_lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_quo got=%h exp=fffffffd", z_lo); end
    checks++; if (z_hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_rem got=%h exp=ffffffff", z_hi); end
    checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL div_dbz got=%b exp=0", dbz); end
    run_op(5'd3, 32'd100, 32'hFFFFFFF9, lat, bc);
    checks++;
    if (z_lo !== 32'hFFFFFFF2 || z_hi !== 32'd2) begin
      failures++; $display("FAIL div_pos_neg got q=%h r=%h exp q=fffffff2 r=00000002", z_lo, z_hi);
    end
    run_op(5'd3, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    checks++;
    if (z_lo !== 32'h80000000 || z_hi !== 32'h0 || dbz !== 1'b0) begin
      failures++; $display("FAIL div_most_neg got q=%h r=%h dbz=%b exp q=80000000 r=0 dbz=0", z_lo, z_hi, dbz);
    end
  endtask

  task automatic test_div_by_zero;
    int lat, bc;
    run_op(5'd3, 32'd9, 32'd0, lat, bc);
    checks++; if (lat != 34) begin failures++; $display("FAIL dbz_latency got=%0d exp=34", lat); end
    checks++; if (z_lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL dbz_zlo got=%h exp=ffffffff", z_lo); end
    checks++; if (z_hi !== 32'd9) begin failures++; $display("FAIL dbz_zhi got=%h exp=00000009", z_hi); end
    checks++; if (dbz !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", dbz); end
    repeat (3) @(negedge clk);
    checks++;
    if (dbz !== 1'b1 || z_lo !== 32'hFFFFFFFF || done !== 1'b0) begin
      failures++; $display("FAIL dbz_hold got dbz=%b lo=%h done=%b exp dbz=1 lo=ffffffff done=0", dbz, z_lo, done);
    end
    run_op(5'd0, 32'd1, 32'd1, lat, bc);
    checks++;
    if (z_lo !== 32'd2 || dbz !== 1'b0) begin
      failures++; $display("FAIL dbz_clear got lo=%h dbz=%b exp lo=00000002 dbz=0", z_lo, dbz);
    end
    run_op(5'd3, 32'hFFFFFFFB, 32'd0, lat, bc);
    checks++;
    if (z_hi !== 32'hFFFFFFFB || z_lo !== 32'hFFFFFFFF || dbz !== 1'b1) begin
      failures++; $display("FAIL dbz_neg got hi=%h lo=%h dbz=%b exp hi=fffffffb lo=ffffffff dbz=1", z_hi, z_lo, dbz);
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    logic busy_at_req;
    @(negedge clk);
    start = 1'b1; ctrl = 5'd2; a_in = 32'd6; b_in = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    busy_at_req = busy;
    start = 1'b1; ctrl = 5'd0; a_in = 32'd1; b_in = 32'd1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    checks++; if (busy_at_req !== 1'b1) begin failures++; $display("FAIL ignore_busy got=%b exp=1", busy_at_req); end
    checks++; if (lat != 34) begin failures++; $display("FAIL ignore_latency got=%0d exp=34", lat); end
    checks++;
    if (z_lo !== 32'd42 || z_hi !== 32'd0) begin
      failures++; $display("FAIL ignore_result got=%h_%h exp=00000000_0000002a", z_hi, z_lo);
    end
  endtask

  task automatic test_reset_mid_op;
    int k, done_seen, lat, bc;
    @(negedge clk);
    start = 1'b1; ctrl = 5'd3; a_in = 32'd100; b_in = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (k < 10) begin @(negedge clk); k++; end
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (z_hi !== 32'h0 || z_lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs got hi=%h lo=%h busy=%b done=%b dbz=%b exp all 0",
               z_hi, z_lo, busy, done, dbz);
    end
    clr = 1'b1;
    done_seen = 0;
    repeat (40) begin @(negedge clk); if (done) done_seen++; end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", done_seen); end
    run_op(5'd2, 32'hFFFFFFFD, 32'd4, lat, bc);
    checks++;
    if (lat != 34 || z_hi !== 32'hFFFFFFFF || z_lo !== 32'hFFFFFFF4) begin
      failures++; $display("FAIL midreset_resume got lat=%0d %h_%h exp lat=34 ffffffff_fffffff4", lat, z_hi, z_lo);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_single_cycle_ops;
    test_mul;
    test_div;
    test_div_by_zero;
    test_busy_ignore;
    test_reset_mid_op;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
